// File: rtl/kgp_prefix_encoder.sv
// Signed adder front end: per-bit kill/generate/propagate encoding, registered
// Kogge-Stone carry resolution, and sum/carry/overflow with aligned KGP codes.
module kgp_prefix_encoder #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 valid_i,
  output logic                 ready_o,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     b_i,
  input  logic                 cin_i,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic [WIDTH-1:0]     sum_o,
  output logic                 carry_o,
  output logic                 overflow_o,
  output logic [3*WIDTH-1:0]   kgp_o
);

  localparam int unsigned LEVELS = $clog2(WIDTH);

  typedef enum logic [2:0] {
    KILL = 3'b000,
    GEN  = 3'b001,
    PROP = 3'b010
  } code_e;

  // Index j holds position j-1; index 0 is the carry-in pseudo-bit.
  typedef logic [WIDTH:0][2:0] grp_t;
  typedef logic [WIDTH-1:0][2:0] kgp_t;

  function automatic logic [2:0] combine(input logic [2:0] hi, input logic [2:0] lo);
    case (hi)
      GEN:     combine = GEN;
      PROP:    combine = lo;
      default: combine = KILL;
    endcase
  endfunction

  logic              en;
  grp_t              enc;
  grp_t              grp_d [LEVELS+1];
  grp_t              grp_q [LEVELS+1];
  kgp_t              kgp_q [LEVELS+1];
  logic [LEVELS:0]   v_q;
  logic [WIDTH:0]    carry;
  logic [WIDTH-1:0]  sum_d;

  assign en      = !valid_o | ready_i;
  assign ready_o = en;

  always_comb begin
    enc    = '0;
    enc[0] = cin_i ? GEN : KILL;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (a_i[i] & b_i[i])
        enc[i+1] = GEN;
      else if (a_i[i] ^ b_i[i])
        enc[i+1] = PROP;
      else
        enc[i+1] = KILL;
    end
  end

  always_comb begin
    for (int unsigned k = 0; k <= LEVELS; k++)
      grp_d[k] = '0;
    grp_d[0] = enc;
    for (int unsigned k = 1; k <= LEVELS; k++) begin
      for (int unsigned j = 0; j <= WIDTH; j++) begin
        if (j >= (32'd1 << (k - 1)))
          grp_d[k][j] = combine(grp_q[k-1][j], grp_q[k-1][j - (32'd1 << (k - 1))]);
        else
          grp_d[k][j] = grp_q[k-1][j];
      end
    end
  end

  // Datapath registers need no reset; only valid bits and outputs do.
  always_ff @(posedge clk_i) begin
    if (en) begin
      for (int unsigned k = 0; k <= LEVELS; k++)
        grp_q[k] <= grp_d[k];
      kgp_q[0] <= enc[WIDTH:1];
      for (int unsigned k = 1; k <= LEVELS; k++)
        kgp_q[k] <= kgp_q[k-1];
    end
  end

  // After LEVELS stages every index below WIDTH spans down to the carry-in;
  // the MSB group still lacks index 0, so fold it in here.
  always_comb begin
    carry = '0;
    sum_d = '0;
    for (int unsigned i = 0; i < WIDTH; i++)
      carry[i] = (grp_q[LEVELS][i] == GEN);
    carry[WIDTH] = (combine(grp_q[LEVELS][WIDTH], grp_q[LEVELS][0]) == GEN);
    for (int unsigned i = 0; i < WIDTH; i++)
      sum_d[i] = (kgp_q[LEVELS][i] == PROP) ^ carry[i];
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      v_q        <= '0;
      valid_o    <= 1'b0;
      sum_o      <= '0;
      carry_o    <= 1'b0;
      overflow_o <= 1'b0;
      kgp_o      <= '0;
    end else if (en) begin
      v_q        <= {v_q[LEVELS-1:0], valid_i};
      valid_o    <= v_q[LEVELS];
      sum_o      <= sum_d;
      carry_o    <= carry[WIDTH];
      overflow_o <= carry[WIDTH] ^ carry[WIDTH-1];
      kgp_o      <= kgp_q[LEVELS];
    end
  end

endmodule

// File: doc/kgp_prefix_encoder.md
Name: kgp_prefix_encoder

Overview:
Pipelined signed adder front end that turns two WIDTH-bit operands into per-bit kill/generate/propagate codes. It resolves all carries with a registered Kogge-Stone prefix network and emits sum, carry-out and signed overflow. It also emits the per-bit KGP codes in the 3-bit select format consumed by the adder's 3-to-1 select muxes. Sits between operand registers and the sum/select stage of the signed adder datapath.

Parameters:
WIDTH, 8, operand width in bits; power of two, range 2..64
LEVELS, $clog2(WIDTH), number of prefix stages; derived, not overridable

Ports:
clk_i  input  1  clock, rising edge
rst_ni  input  1  asynchronous active-low reset
valid_i  input  1  operand beat valid
ready_o  output  1  block accepts beat this cycle
a_i  input  WIDTH  operand A, two's complement
b_i  input  WIDTH  operand B, two's complement
cin_i  input  1  carry-in
valid_o  output  1  result valid
ready_i  input  1  downstream accepts result
sum_o  output  WIDTH  A+B+cin, low WIDTH bits
carry_o  output  1  carry out of MSB
overflow_o  output  1  signed overflow
kgp_o  output  3*WIDTH  per-bit code; bits [3i+2:3i] belong to bit i

Behaviour:
- Code encoding, same as the select muxes: KILL=3'b000 (a=b=0), GEN=3'b001 (a=b=1), PROP=3'b010 (a!=b). Codes 011..111 are never produced.
- Carry-in is modelled as position -1: GEN if cin_i=1, else KILL.
- Combine operator (hi o lo): hi=KILL -> KILL; hi=GEN -> GEN; hi=PROP -> lo.
- Stage E (encode): register per-bit codes, operands and cin.
- Stages P1..PLEVELS: level k combines position i with position i-2^(k-1). Positions below -1 act as identity (pass through).
- Stage S: carry into bit i is c_i = (group[i-1..-1]==GEN), with c_0=cin. sum_i = a_i^b_i^c_i. carry_o = c_WIDTH. overflow_o = c_WIDTH ^ c_(WIDTH-1).
- kgp_o carries the stage-E codes, delayed to align with sum_o.
- Latency: LEVELS+2 cycles from accepted beat to valid_o. WIDTH=8 gives 5.
- Handshake: global enable en = !valid_o | ready_i. ready_o = en. A beat is accepted when valid_i & ready_o. Every stage register, including the per-stage valid bits, advances only when en=1.
- Throughput: one beat per cycle when ready_i=1. Bubbles propagate as valid=0 stages.
- Stall (valid_o=1, ready_i=0): all stages hold, ready_o=0, and outputs stay stable until the transfer completes. Inputs presented while ready_o=0 are ignored.
- Simultaneous accept and output transfer in the same cycle is legal, with no bubble inserted.
- Reset, async assert: all stage valid bits clear, valid_o=0, sum_o=0, carry_o=0, overflow_o=0, kgp_o=0. ready_o reads 1 once reset is applied.
- Reset mid-operation: in-flight beats are discarded and never appear at the output.
- Reset deassertion is synchronized externally. The first accept can occur on the first clock edge after deassertion.
- Datapath registers may be non-reset. Only the valid bits and the output registers must reset.

Test Plan:
1. WIDTH=8, a=0x7F, b=0x01, cin=0 -> after 5 cycles: sum_o=0x80, carry_o=0, overflow_o=1.
2. a=0xFF, b=0x01, cin=0 -> sum_o=0x00, carry_o=1, overflow_o=0; kgp_o bit0 = 3'b001, bits 1..7 = 3'b010.
3. a=0x0F, b=0xF0, cin=1 (full propagate chain) -> kgp_o=24'h492492, sum_o=0x00, carry_o=1, overflow_o=0. With cin=0 instead: sum_o=0xFF, carry_o=0.
4. a=0x80, b=0x80, cin=0 -> sum_o=0x00, carry_o=1, overflow_o=1, kgp_o bit7=3'b001, bits 0..6=3'b000.
5. Back-to-back stream of 20 random beats with ready_i toggled randomly -> every beat is delivered once, in order, with no loss or duplication. Outputs hold while stalled, and ready_o=0 exactly when valid_o=1 & ready_i=0. Results match a reference model.
6. Inject 3 beats, assert rst_ni low for 1 cycle at cycle 2 -> valid_o=0 and all outputs 0 immediately. No stale beat appears afterwards. A new beat (0x01+0x01) yields sum_o=0x02 after 5 cycles.
